// File: rtl/coef_table_writer.sv
// coef_table_writer: streams coefficient words from a valid/ready source into a
// DEPTH-entry coefficient RAM at addresses 0..DEPTH-1. It reports load progress,
// completion, a running XOR checksum and a sticky overflow flag for words offered
// after the table is full.
module coef_table_writer #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_en,
  input  logic                  start,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [DATA_WIDTH-1:0] checksum
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_cnt;
  logic                  accept;

  // Ready only while loading and not frozen; derived from registered state.
  assign s_ready = (state == LOAD) && clk_en;
  assign accept  = s_valid && s_ready;

  // Load FSM with registered write port, status flags and running checksum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      addr_cnt <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      checksum <= '0;
    end else if (!clk_en) begin
      // Frozen: everything holds except the write strobe, which must not repeat.
      wr_en <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD;
            addr_cnt <= '0;
            checksum <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
            busy     <= 1'b1;
          end
        end
        LOAD: begin
          // start is ignored here; the load always runs to DEPTH words.
          if (accept) begin
            wr_en    <= 1'b1;
            wr_addr  <= addr_cnt;
            wr_data  <= s_data;
            checksum <= checksum ^ s_data;
            if (addr_cnt == LAST_ADDR) begin
              // Counter stays at the last address so it can never wrap.
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              addr_cnt <= addr_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          // A start in the same cycle as a stray word wins; the word is dropped.
          if (start) begin
            state    <= LOAD;
            addr_cnt <= '0;
            checksum <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
            busy     <= 1'b1;
          end else if (s_valid) begin
            overflow <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coef_table_writer.sv
// Testbench for coef_table_writer: vector table, directed sequences and
// randomized traffic against a queue-based reference model (DEPTH=8), plus a
// full 512-word load on a second instance.
module tb_coef_table_writer;

  localparam int AW     = 3;
  localparam int DW     = 16;
  localparam int DEPTH  = 8;
  localparam int AWB    = 9;
  localparam int DEPTHB = 512;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Small instance
  logic          clk_en, start, s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready, wr_en, busy, done, overflow;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data, checksum;

  // Large instance
  logic           b_clk_en, b_start, b_valid;
  logic [DW-1:0]  b_data;
  logic           b_ready, b_wr_en, b_busy, b_done, b_ovf;
  logic [AWB-1:0] b_wr_addr;
  logic [DW-1:0]  b_wr_data, b_sum;

  coef_table_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .start(start), .s_valid(s_valid),
    .s_data(s_data), .s_ready(s_ready), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done), .overflow(overflow),
    .checksum(checksum)
  );

  coef_table_writer #(.ADDR_WIDTH(AWB), .DATA_WIDTH(DW)) dut_big (
    .clk(clk), .rst(rst), .clk_en(b_clk_en), .start(b_start), .s_valid(b_valid),
    .s_data(b_data), .s_ready(b_ready), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
    .wr_data(b_wr_data), .busy(b_busy), .done(b_done), .overflow(b_ovf),
    .checksum(b_sum)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (DEPTH=8) ----------------
  bit            m_loading, m_done, m_ovf;
  logic [DW-1:0] m_words[$];
  logic          m_wr_en;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  function automatic logic [DW-1:0] m_sum();
    logic [DW-1:0] x = '0;
    foreach (m_words[i]) x ^= m_words[i];
    return x;
  endfunction

  task automatic model_reset();
    m_loading = 0; m_done = 0; m_ovf = 0; m_words.delete();
    m_wr_en = 0; m_addr = '0; m_data = '0;
  endtask

  // One clock edge worth of behaviour, from the load rules in plain terms.
  task automatic model_edge(input logic st, input logic v, input logic [DW-1:0] d, input logic en);
    m_wr_en = 0;
    if (!en) return;
    if (m_loading) begin
      if (v) begin
        m_wr_en = 1;
        m_addr  = AW'(m_words.size());
        m_data  = d;
        m_words.push_back(d);
        if (m_words.size() == DEPTH) begin
          m_loading = 0;
          m_done    = 1;
        end
      end
    end else if (st) begin
      m_loading = 1; m_done = 0; m_ovf = 0; m_words.delete();
    end else if (m_done && v) begin
      m_ovf = 1;
    end
  endtask

  function automatic logic [63:0] pack_dut();
    return 64'({wr_en, wr_addr, wr_data, busy, done, overflow, checksum});
  endfunction

  function automatic logic [63:0] pack_model();
    return 64'({m_wr_en, m_addr, m_data, m_loading, m_done, m_ovf, m_sum()});
  endfunction

  // Apply inputs for one cycle (called #1 after a rising edge), check against model.
  task automatic step(input logic st, input logic v, input logic [DW-1:0] d, input logic en);
    start = st; s_valid = v; s_data = d; clk_en = en;
    #1;
    check("s_ready", 64'(s_ready), 64'(m_loading & en));
    @(posedge clk);
    model_edge(st, v, d, en);
    #1;
    check("outputs", pack_dut(), pack_model());
  endtask

  // Assert reset in the middle of a cycle and check the outputs clear at once.
  task automatic async_reset();
    start = 0; s_valid = 0; clk_en = 1;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_async", 64'({s_ready, pack_dut()}), 64'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    check("rst_hold", 64'({s_ready, pack_dut()}), 64'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          st, v, en;
    logic [DW-1:0] d;
    logic          rdy, we;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    logic          bsy, dn, ovf;
    logic [DW-1:0] sum;
  } vec_t;

  vec_t tbl[12];

  initial begin
    logic [DW-1:0] pfx[8];
    pfx = '{16'h1, 16'h3, 16'h0, 16'h4, 16'h1, 16'h7, 16'h0, 16'h8};
    // start, 8 words 1..8, stray 0xBEEF after full, idle, restart
    tbl[0] = '{1, 0, 1, 16'h0, 0, 0, 3'd0, 16'h0, 1, 0, 0, 16'h0};
    for (int i = 1; i <= 8; i++)
      tbl[i] = '{0, 1, 1, DW'(i), 1, 1, AW'(i - 1), DW'(i), (i < 8), (i == 8), 0, pfx[i-1]};
    tbl[9]  = '{0, 1, 1, 16'hBEEF, 0, 0, 3'd7, 16'h8, 0, 1, 1, 16'h8};
    tbl[10] = '{0, 0, 1, 16'h0,    0, 0, 3'd7, 16'h8, 0, 1, 1, 16'h8};
    tbl[11] = '{1, 0, 1, 16'h0,    0, 0, 3'd7, 16'h8, 1, 0, 0, 16'h0};

    rst = 1'b1; clk_en = 0; start = 0; s_valid = 0; s_data = '0;
    b_clk_en = 0; b_start = 0; b_valid = 0; b_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_state", 64'({s_ready, pack_dut()}), 64'd0);

    // Table-driven basic load and overflow
    for (int i = 0; i < 12; i++) begin
      start = tbl[i].st; s_valid = tbl[i].v; s_data = tbl[i].d; clk_en = tbl[i].en;
      #1;
      check($sformatf("tbl%0d_ready", i), 64'(s_ready), 64'(tbl[i].rdy));
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_out", i), pack_dut(),
            64'({tbl[i].we, tbl[i].a, tbl[i].wd, tbl[i].bsy, tbl[i].dn, tbl[i].ovf, tbl[i].sum}));
    end

    // Model-driven directed sequences start from a clean reset
    async_reset();

    // start+s_valid together in IDLE: start taken, word not accepted
    step(1, 1, 16'hAAAA, 1);
    // s_valid toggling 1,0,1,0 during the load
    for (int i = 0; i < 16; i++) step(0, (i % 2 == 0), DW'(16'h100 + i), 1);
    check("toggle_done", 64'(done), 64'd1);

    // clk_en low for 3 cycles at addr 4, start pulses lost meanwhile
    step(1, 0, '0, 1);
    for (int i = 0; i < 4; i++) step(0, 1, DW'(16'h20 + i), 1);
    for (int i = 0; i < 3; i++) step(1, 1, 16'hDEAD, 0);
    for (int i = 4; i < 8; i++) step(0, 1, DW'(16'h20 + i), 1);
    check("clken_last_addr", 64'(wr_addr), 64'd7);
    check("clken_done", 64'(done), 64'd1);
    // start together with a stray word in DONE: reload, no overflow
    step(1, 1, 16'h5555, 1);
    check("done_start_ovf", 64'(overflow), 64'd0);

    // reset after 5 words, then a complete reload
    for (int i = 0; i < 5; i++) step(0, 1, DW'(16'h40 + i), 1);
    async_reset();
    step(1, 0, '0, 1);
    for (int i = 0; i < 8; i++) step(0, 1, DW'(16'h60 + i), 1);
    check("reload_done", 64'(done), 64'd1);

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      step(($urandom % 16) == 0, ($urandom % 3) != 0, DW'($urandom), ($urandom % 8) != 0);

    // ---------------- 512-entry load ----------------
    begin
      logic [DW-1:0] bq[$];
      logic [DW-1:0] bx;
      int writes, bad, cyc;
      logic last_done;
      bx = '0; writes = 0; bad = 0; cyc = 0; last_done = 0;
      start = 0; s_valid = 0; clk_en = 1;
      b_clk_en = 1; b_start = 1; b_valid = 0;
      @(posedge clk); #1;
      b_start = 0;
      while (writes < DEPTHB && cyc < 4000) begin
        b_valid = ($urandom % 4) != 0;
        b_data  = DW'($urandom);
        #1;
        if (b_ready !== 1'b1) bad++;
        if (b_valid) begin bq.push_back(b_data); bx ^= b_data; end
        @(posedge clk); #1;
        cyc++;
        if (b_wr_en) begin
          if (b_wr_addr !== AWB'(writes) || b_wr_data !== bq[writes]) bad++;
          writes++;
          last_done = b_done;
          if (writes < DEPTHB && b_done) bad++;
        end else if (b_valid) begin
          bad++;
        end
      end
      b_valid = 0;
      check("big_writes", 64'(writes), 64'(DEPTHB));
      check("big_errors", 64'(bad), 64'd0);
      check("big_done_with_last", 64'(last_done), 64'd1);
      check("big_status", 64'({b_busy, b_done, b_ovf}), 64'b010);
      check("big_checksum", 64'(b_sum), 64'(bx));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
